max7219_seq: RTL and testbench



---
 rtl/max7219_seq.sv | 268 ++++++++++++++++++++++++++
 tb/tb_max7219_seq.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/max7219_seq.sv
// max7219_seq
// Command sequencer in front of the max7219 serial driver.
// After reset it runs the MAX7219 power-up configuration. It then rewrites
// the digit registers from a parallel display image on request, and rewrites
// the intensity register whenever the intensity input changes.
//
// Parameters:
//   NUM_DIGITS   digits refreshed (1-8); scan-limit is written with NUM_DIGITS-1
//   DECODE_MODE  value written to the decode-mode register (0x9)
// Ports:
//   i_clk        system clock, shared with max7219
//   i_reset_n    asynchronous active-low reset
//   i_en         sequencer enable; low parks the FSM after the current transfer
//   i_update     single-cycle request for a full digit refresh
//   i_digits     display image, byte k goes to digit register k+1
//   i_intensity  intensity value for register 0xA
//   o_stb        one-cycle transfer strobe to the driver
//   o_addr       register address to the driver
//   o_data       register data to the driver
//   i_drv_busy   driver busy flag
//   i_drv_ack    driver end-of-frame acknowledge
//   o_init_done  high once the configuration sequence has completed
//   o_busy       high while a job is in progress
module max7219_seq #(
  parameter int          NUM_DIGITS  = 8,
  parameter logic [7:0]  DECODE_MODE = 8'hFF
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_en,
  input  logic                    i_update,
  input  logic [8*NUM_DIGITS-1:0] i_digits,
  input  logic [3:0]              i_intensity,
  output logic                    o_stb,
  output logic [3:0]              o_addr,
  output logic [7:0]              o_data,
  input  logic                    i_drv_busy,
  input  logic                    i_drv_ack,
  output logic                    o_init_done,
  output logic                    o_busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT_REQ,
    S_SEND,
    S_WAIT,
    S_NEXT
  } state_t;

  typedef enum logic [1:0] {
    JOB_CONFIG,
    JOB_REFRESH,
    JOB_INTENS
  } job_t;

  localparam logic [2:0] LAST_CFG   = 3'd5;
  localparam logic [2:0] LAST_DIGIT = 3'(NUM_DIGITS - 1);
  localparam logic [4:0] ACK_LIMIT  = 5'd31;

  state_t                        r_state;
  job_t                          r_job;
  logic [2:0]                    r_idx;
  logic [NUM_DIGITS-1:0][7:0]    r_snap;
  logic                          r_stb;
  logic [3:0]                    r_addr;
  logic [7:0]                    r_data;
  logic                          r_init_done;
  logic                          r_busy;
  logic                          r_pend_upd;
  logic                          r_pend_int;
  logic [3:0]                    r_last_int;
  logic [4:0]                    r_wait_cnt;

  state_t                        w_state_nxt;
  job_t                          w_job_nxt;
  logic [2:0]                    w_idx_nxt;
  logic                          w_snap_load;
  logic                          w_upd_take;
  logic                          w_init_set;
  logic                          w_issue;
  logic                          w_int_write;
  logic                          w_int_req;
  logic                          w_upd_req;
  logic [NUM_DIGITS-1:0][7:0]    w_snap_nxt;
  logic [3:0]                    w_cmd_addr;
  logic [7:0]                    w_cmd_data;

  // A changed intensity only counts as a job once the device is configured;
  // before that the configuration list writes it anyway.
  assign w_int_req = r_pend_int | (r_init_done & (i_intensity != r_last_int));
  assign w_upd_req = r_pend_upd | i_update;

  // Next-state logic. Job selection happens both from IDLE and at the end of
  // a job in NEXT, so back-to-back jobs keep the 20-cycle command spacing.
  always_comb begin
    w_state_nxt = r_state;
    w_job_nxt   = r_job;
    w_idx_nxt   = r_idx;
    w_snap_load = 1'b0;
    w_upd_take  = 1'b0;
    w_init_set  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_en) begin
          if (!r_init_done) begin
            w_state_nxt = S_INIT_REQ;
          end else if (w_int_req) begin
            w_job_nxt   = JOB_INTENS;
            w_idx_nxt   = 3'd0;
            w_state_nxt = S_SEND;
          end else if (w_upd_req) begin
            w_job_nxt   = JOB_REFRESH;
            w_idx_nxt   = 3'd0;
            w_snap_load = 1'b1;
            w_upd_take  = 1'b1;
            w_state_nxt = S_SEND;
          end
        end
      end
      S_INIT_REQ: begin
        if (i_en) begin
          w_job_nxt   = JOB_CONFIG;
          w_idx_nxt   = 3'd0;
          w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        // A strobe already issued always completes; an unissued command is
        // abandoned when the sequencer is disabled.
        if (r_stb) begin
          w_state_nxt = S_WAIT;
        end else if (!i_en) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        if (i_drv_ack) begin
          w_state_nxt = S_NEXT;
        end else if (r_wait_cnt == ACK_LIMIT) begin
          w_state_nxt = S_SEND;
        end
      end
      S_NEXT: begin
        if (!i_en) begin
          w_state_nxt = S_IDLE;
        end else if ((r_job == JOB_CONFIG && r_idx != LAST_CFG) ||
                     (r_job == JOB_REFRESH && r_idx != LAST_DIGIT)) begin
          w_idx_nxt   = r_idx + 3'd1;
          w_state_nxt = S_SEND;
        end else if (r_job == JOB_CONFIG) begin
          w_init_set  = 1'b1;
          w_job_nxt   = JOB_REFRESH;
          w_idx_nxt   = 3'd0;
          w_snap_load = 1'b1;
          w_upd_take  = 1'b1;
          w_state_nxt = S_SEND;
        end else if (w_int_req) begin
          w_job_nxt   = JOB_INTENS;
          w_idx_nxt   = 3'd0;
          w_state_nxt = S_SEND;
        end else if (w_upd_req) begin
          w_job_nxt   = JOB_REFRESH;
          w_idx_nxt   = 3'd0;
          w_snap_load = 1'b1;
          w_upd_take  = 1'b1;
          w_state_nxt = S_SEND;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // The strobe is issued on the same edge that enters (or stays in) SEND,
  // which is what gives a one-cycle latency from an update seen in IDLE.
  assign w_issue     = (w_state_nxt == S_SEND) && i_en && !i_drv_busy;
  assign w_snap_nxt  = w_snap_load ? i_digits : r_snap;
  assign w_int_write = w_issue && (w_cmd_addr == 4'hA);

  // Command lookup for the command about to be issued. The snapshot is
  // bypassed on the edge it is loaded so the first digit sees the new image.
  always_comb begin
    w_cmd_addr = 4'hC;
    w_cmd_data = 8'h01;
    unique case (w_job_nxt)
      JOB_CONFIG: begin
        unique case (w_idx_nxt)
          3'd0:    begin w_cmd_addr = 4'hC; w_cmd_data = 8'h00; end
          3'd1:    begin w_cmd_addr = 4'hF; w_cmd_data = 8'h00; end
          3'd2:    begin w_cmd_addr = 4'h9; w_cmd_data = DECODE_MODE; end
          3'd3:    begin w_cmd_addr = 4'hB; w_cmd_data = 8'(NUM_DIGITS - 1); end
          3'd4:    begin w_cmd_addr = 4'hA; w_cmd_data = {4'h0, i_intensity}; end
          default: begin w_cmd_addr = 4'hC; w_cmd_data = 8'h01; end
        endcase
      end
      JOB_REFRESH: begin
        w_cmd_addr = 4'(w_idx_nxt) + 4'd1;
        w_cmd_data = w_snap_nxt[w_idx_nxt];
      end
      default: begin
        w_cmd_addr = 4'hA;
        w_cmd_data = {4'h0, i_intensity};
      end
    endcase
  end

  // State, job bookkeeping and registered outputs.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= S_INIT_REQ;
      r_job       <= JOB_CONFIG;
      r_idx       <= 3'd0;
      r_snap      <= '0;
      r_stb       <= 1'b0;
      r_addr      <= 4'h0;
      r_data      <= 8'h00;
      r_init_done <= 1'b0;
      r_busy      <= 1'b0;
      r_pend_upd  <= 1'b0;
      r_pend_int  <= 1'b0;
      r_last_int  <= 4'h0;
      r_wait_cnt  <= 5'd0;
    end else begin
      r_state <= w_state_nxt;
      r_job   <= w_job_nxt;
      r_idx   <= w_idx_nxt;
      if (w_snap_load) begin
        r_snap <= i_digits;
      end
      r_stb <= w_issue;
      if (w_issue) begin
        r_addr <= w_cmd_addr;
        r_data <= w_cmd_data;
      end
      r_wait_cnt <= (r_state == S_WAIT) ? r_wait_cnt + 5'd1 : 5'd0;
      r_busy     <= (w_state_nxt == S_SEND) || (w_state_nxt == S_WAIT) ||
                    (w_state_nxt == S_NEXT);
      // Disabling forces a full reconfiguration on the next enable.
      if (!i_en) begin
        r_init_done <= 1'b0;
      end else if (w_init_set) begin
        r_init_done <= 1'b1;
      end
      // Starting a refresh consumes every request seen so far, including
      // one arriving on that very edge.
      if (w_upd_take) begin
        r_pend_upd <= 1'b0;
      end else if (i_update) begin
        r_pend_upd <= 1'b1;
      end
      if (w_int_write) begin
        r_pend_int <= 1'b0;
        r_last_int <= i_intensity;
      end else if (r_init_done && (i_intensity != r_last_int)) begin
        r_pend_int <= 1'b1;
      end
    end
  end

  assign o_stb       = r_stb;
  assign o_addr      = r_addr;
  assign o_data      = r_data;
  assign o_init_done = r_init_done;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_max7219_seq.sv
// tb_max7219_seq
// Self-checking bench for max7219_seq. A behavioural driver model answers
// each strobe with 17 busy cycles and an ack, and logs every accepted
// command word together with o_init_done and the cycle it was strobed.
// Expected command lists are built from the configuration and refresh
// rules and compared against that log.
module tb_max7219_seq;

  localparam int N = 8;

  logic           i_clk = 1'b0;
  logic           i_reset_n;
  logic           i_en;
  logic           i_update;
  logic [8*N-1:0] i_digits;
  logic [3:0]     i_intensity;
  logic           o_stb;
  logic [3:0]     o_addr;
  logic [7:0]     o_data;
  logic           drvBusy = 1'b0;
  logic           drvAck = 1'b0;
  logic           o_init_done;
  logic           o_busy;

  int checkCount = 0;
  int errorCount = 0;

  always #5 i_clk = ~i_clk;

  max7219_seq #(.NUM_DIGITS(N), .DECODE_MODE(8'hFF)) dut (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_en        (i_en),
    .i_update    (i_update),
    .i_digits    (i_digits),
    .i_intensity (i_intensity),
    .o_stb       (o_stb),
    .o_addr      (o_addr),
    .o_data      (o_data),
    .i_drv_busy  (drvBusy),
    .i_drv_ack   (drvAck),
    .o_init_done (o_init_done),
    .o_busy      (o_busy)
  );

  // Driver model: accepts a strobe only when idle, stays busy 17 cycles and
  // acks on the cycle after. A pending drop request swallows one ack.
  int          drvCnt = 0;
  int          cycleNo = 0;
  int          collisions = 0;
  int          dropReq = 0;
  int          dropDone = 0;
  logic [12:0] logQ[$];
  int          cycQ[$];

  always @(posedge i_clk) begin
    cycleNo <= cycleNo + 1;
    drvAck  <= 1'b0;
    if (o_stb) begin
      if (drvCnt != 0) begin
        collisions <= collisions + 1;
      end else begin
        logQ.push_back({o_init_done, o_addr, o_data});
        cycQ.push_back(cycleNo);
      end
    end
    if (drvCnt != 0) begin
      if (drvCnt == 17) begin
        drvBusy <= 1'b0;
        drvCnt  <= 0;
        if (dropReq != dropDone) dropDone <= dropDone + 1;
        else drvAck <= 1'b1;
      end else begin
        drvCnt <= drvCnt + 1;
      end
    end else if (o_stb) begin
      drvBusy <= 1'b1;
      drvCnt  <= 1;
    end
  end

  logic [12:0] expQ[$];
  logic [3:0]  curIntens;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [8*N-1:0] digits, input logic [3:0] intens,
                               input logic upd);
    @(negedge i_clk);
    i_digits    = digits;
    i_intensity = intens;
    i_update    = upd;
    @(negedge i_clk);
    i_update    = 1'b0;
  endtask

  task automatic pushWord(input logic init, input logic [3:0] addr, input logic [7:0] data);
    expQ.push_back({init, addr, data});
  endtask

  task automatic expectConfig(input logic [3:0] intens);
    pushWord(1'b0, 4'hC, 8'h00);
    pushWord(1'b0, 4'hF, 8'h00);
    pushWord(1'b0, 4'h9, 8'hFF);
    pushWord(1'b0, 4'hB, 8'(N - 1));
    pushWord(1'b0, 4'hA, {4'h0, intens});
    pushWord(1'b0, 4'hC, 8'h01);
  endtask

  task automatic expectRefresh(input logic [8*N-1:0] img);
    for (int k = 0; k < N; k++) pushWord(1'b1, 4'(k + 1), img[8*k +: 8]);
  endtask

  // Waits for a job to start and then for the sequencer to go idle.
  task automatic waitDone();
    int n;
    n = 0;
    while (!o_busy && n < 50) begin @(negedge i_clk); n++; end
    if (!o_busy) checkOutput("busyRiseTimeout", 64'd0, 64'd1);
    n = 0;
    while (o_busy && n < 3000) begin @(negedge i_clk); n++; end
    if (o_busy) checkOutput("idleTimeout", 64'd1, 64'd0);
    repeat (3) @(negedge i_clk);
  endtask

  task automatic waitAddrStb(input logic [3:0] addr);
    int n;
    n = 0;
    while (!(o_stb && o_addr == addr) && n < 200) begin @(negedge i_clk); n++; end
    if (!(o_stb && o_addr == addr)) checkOutput("stbWaitTimeout", 64'd0, 64'd1);
  endtask

  // Compares the words logged since 'base' with the expected list, and the
  // strobe spacing; retryIdx marks the one gap that follows a lost ack.
  task automatic checkBurst(input int base, input int retryIdx);
    int gap;
    checkOutput("wordCount", 64'(logQ.size() - base), 64'(expQ.size()));
    for (int i = 0; i < expQ.size(); i++) begin
      if (base + i < logQ.size()) begin
        checkOutput($sformatf("word%0d", i), 64'(logQ[base + i]), 64'(expQ[i]));
        if (i > 0) begin
          gap = cycQ[base + i] - cycQ[base + i - 1];
          if (i == retryIdx) checkOutput("retryGap", 64'(gap >= 32 && gap <= 34), 64'd1);
          else checkOutput($sformatf("gap%0d", i), 64'(gap), 64'd20);
        end
      end
    end
    expQ.delete();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors so far %0d", errorCount);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          base;
    logic [8*N-1:0] img;
    logic [8*N-1:0] imgB;
    logic [3:0]  newI;

    i_reset_n   = 1'b0;
    i_en        = 1'b1;
    i_update    = 1'b0;
    i_intensity = 4'h5;
    i_digits    = 64'h0807060504030201;
    curIntens   = 4'h5;
    #12;
    checkOutput("rstStb", 64'(o_stb), 64'd0);
    checkOutput("rstAddr", 64'(o_addr), 64'd0);
    checkOutput("rstData", 64'(o_data), 64'd0);
    checkOutput("rstInitDone", 64'(o_init_done), 64'd0);
    checkOutput("rstBusy", 64'(o_busy), 64'd0);

    $display("[TB] power-up configuration and first refresh");
    @(negedge i_clk);
    base = logQ.size();
    i_reset_n = 1'b1;
    expectConfig(4'h5);
    expectRefresh(64'h0807060504030201);
    waitDone();
    checkBurst(base, -1);
    checkOutput("initDoneHigh", 64'(o_init_done), 64'd1);

    $display("[TB] update from idle, latency check");
    img = {$urandom, $urandom};
    img[7:0] = 8'h7E;
    base = logQ.size();
    applyStimulus(img, curIntens, 1'b1);
    checkOutput("latStb", 64'(o_stb), 64'd1);
    checkOutput("latAddr", 64'(o_addr), 64'd1);
    checkOutput("latData", 64'(o_data), 64'h7E);
    expectRefresh(img);
    waitDone();
    checkBurst(base, -1);
    checkOutput("busyLow", 64'(o_busy), 64'd0);

    $display("[TB] collapsed updates with image change mid-job");
    img  = {$urandom, $urandom};
    imgB = {$urandom, $urandom};
    base = logQ.size();
    applyStimulus(img, curIntens, 1'b1);
    repeat (30) @(negedge i_clk);
    applyStimulus(imgB, curIntens, 1'b1);
    repeat (40) @(negedge i_clk);
    applyStimulus(imgB, curIntens, 1'b1);
    repeat (40) @(negedge i_clk);
    applyStimulus(imgB, curIntens, 1'b1);
    expectRefresh(img);
    expectRefresh(imgB);
    waitDone();
    checkBurst(base, -1);

    $display("[TB] intensity change together with update");
    base = logQ.size();
    applyStimulus(imgB, 4'hA, 1'b1);
    pushWord(1'b1, 4'hA, 8'h0A);
    expectRefresh(imgB);
    curIntens = 4'hA;
    waitDone();
    checkBurst(base, -1);
    base = logQ.size();
    applyStimulus(imgB, curIntens, 1'b1);
    expectRefresh(imgB);
    waitDone();
    checkBurst(base, -1);

    $display("[TB] randomized image/intensity updates");
    for (int it = 0; it < 4; it++) begin
      img  = {$urandom, $urandom};
      newI = ($urandom_range(0, 1) == 1) ? 4'($urandom) : curIntens;
      base = logQ.size();
      if (newI != curIntens) pushWord(1'b1, 4'hA, {4'h0, newI});
      expectRefresh(img);
      curIntens = newI;
      applyStimulus(img, newI, 1'b1);
      waitDone();
      checkBurst(base, -1);
    end

    $display("[TB] lost ack triggers a retry");
    img  = {$urandom, $urandom};
    base = logQ.size();
    dropReq = dropReq + 1;
    pushWord(1'b1, 4'h1, img[7:0]);
    expectRefresh(img);
    applyStimulus(img, curIntens, 1'b1);
    waitDone();
    checkBurst(base, 1);

    $display("[TB] disable during digit 3, then re-enable");
    img  = {$urandom, $urandom};
    base = logQ.size();
    applyStimulus(img, curIntens, 1'b1);
    waitAddrStb(4'd3);
    i_en = 1'b0;
    for (int k = 0; k < 3; k++) pushWord(1'b1, 4'(k + 1), img[8*k +: 8]);
    waitDone();
    repeat (60) @(negedge i_clk);
    checkBurst(base, -1);
    checkOutput("initDoneCleared", 64'(o_init_done), 64'd0);
    base = logQ.size();
    i_en = 1'b1;
    expectConfig(curIntens);
    expectRefresh(img);
    waitDone();
    checkBurst(base, -1);

    $display("[TB] asynchronous reset mid-frame");
    img = {$urandom, $urandom};
    applyStimulus(img, curIntens, 1'b1);
    waitAddrStb(4'd2);
    repeat (5) @(negedge i_clk);
    checkOutput("busyBeforeReset", 64'(o_busy), 64'd1);
    #1 i_reset_n = 1'b0;
    #1;
    checkOutput("arstStb", 64'(o_stb), 64'd0);
    checkOutput("arstBusy", 64'(o_busy), 64'd0);
    checkOutput("arstInitDone", 64'(o_init_done), 64'd0);
    checkOutput("arstAddr", 64'(o_addr), 64'd0);
    checkOutput("arstData", 64'(o_data), 64'd0);
    @(negedge i_clk);
    @(negedge i_clk);
    base = logQ.size();
    i_reset_n = 1'b1;
    expectConfig(curIntens);
    expectRefresh(img);
    waitDone();
    checkBurst(base, -1);

    checkOutput("stbWhileBusy", 64'(collisions), 64'd0);
    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
